load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Initiator side of the CPU data-memory interface. Accepts load/store requests from the MEM pipeline stage. Drives the data memory's word-addressed MemRead/MemWrite port. Performs byte/halfword extraction with sign/zero extension on loads, and read-modify-write for sub-word stores. Returns a one-cycle response and flags misaligned accesses without touching memory.

Parameters:
BIG_ENDIAN, 1, 1: byte at addr[1:0]=0 is bits 31:24; 0: bits 7:0
ALIGN_CHECK, 1, 1: misaligned requests error out; 0: addr low bits forced to size alignment

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted on req_valid&req_ready
req_write  in  1  1 store, 0 load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as error)
req_signed  in  1  loads: sign-extend (ignored for word/stores)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_error  out  1  misaligned/illegal size, qualified by resp_valid
mem_address  out  32  byte address to memory (word-aligned, low 2 bits 0)
mem_write_data  out  32  full word to write
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable
mem_read_data  in  32  memory read word, valid within the cycle MemRead is high

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid=0, resp_error=0, resp_rdata=0, MemRead=0, MemWrite=0, mem_address=0, mem_write_data=0; latched request cleared.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1; on accept, latch write/size/signed/addr/wdata.
  - Error (size 11, half with addr[0]=1, word with addr[1:0]!=0, ALIGN_CHECK=1) -> RESP with error.
  - Load or sub-word store -> RD.
  - Word store -> WR.
- RD: MemRead=1, mem_address={addr[31:2],2'b00}. Sample mem_read_data at the closing edge.
  - Load -> RESP with extracted data.
  - Store -> WR.
- WR: MemWrite=1, same mem_address. mem_write_data: word store = wdata; sub-word = sampled word with selected lane(s) replaced by wdata[7:0]/[15:0]. -> RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0 -> IDLE. No backpressure on response.
- Latency from accept edge to resp_valid:
  - Error: cycle 1.
  - Load / word store: cycle 2.
  - Sub-word store: cycle 3.
- Throughput: next request accepted the cycle after RESP (req_ready only in IDLE).
- MemRead and MemWrite never high together; each high for exactly one cycle per access; both 0 in IDLE/RESP.
- mem_address and mem_write_data hold their last values outside RD/WR.
- Lane select: half lane = addr[1]; byte lane = addr[1:0]; ordering per BIG_ENDIAN. Extension per req_signed.
- Reset mid-operation: immediate return to IDLE, enables drop asynchronously, no response. A sub-word store interrupted in RD leaves memory unmodified.
- req inputs are ignored when not in IDLE.

Decomposition:
- Package lsu_pkg: size codes (SZ_BYTE, SZ_HALF, SZ_WORD), state encoding, misalign check function.
- Sub-module lsu_lane_align (combinational): load extract/extend and store merge from (word, addr[1:0], size, signed, wdata). Instantiated once, shared by the RD-load and WR-merge paths.

Test Plan (memory model preloaded with word 1 = 32'h8899AABB, BIG_ENDIAN=1):
1. Load word, addr 4 -> MemRead high exactly cycle 1, MemWrite never high; resp_valid cycle 2; rdata 8899AABB; error 0.
2. Sub-word loads:
   - lb signed addr 5 -> FFFFFF99.
   - lbu addr 5 -> 00000099.
   - lh signed addr 6 -> FFFFAABB.
   - lhu addr 4 -> 00008899.
3. sb addr 7 wdata 0x12345611 -> RD cycle 1, WR cycle 2 with mem_write_data 8899AA11; resp cycle 3; word 1 = 8899AA11.
4. Misaligned access, sh addr 5 and lw addr 6 -> resp_valid cycle 1, error 1, rdata 0; no MemRead/MemWrite; memory unchanged.
5. Mid-operation reset: issue sh addr 4; assert reset during the RD cycle -> MemRead drops without a clock edge; no resp_valid; word 1 unchanged; req_ready=1 after reset releases.
6. Back-to-back requests: hold req_valid with sw addr 8 (0xDEADBEEF) then lw addr 8 -> second accepted only the cycle after first resp_valid; load returns DEADBEEF.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   size_e        - access size codes carried on req_size
//   state_e       - control FSM states
//   is_misaligned - natural-alignment check for a given size and addr[1:0]
//   force_align   - clears the low address bits that a size does not use
// -----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE    = 2'b00,
      SZ_HALF    = 2'b01,
      SZ_WORD    = 2'b10,
      SZ_ILLEGAL = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   // True when the byte offset is not a multiple of the access size.
   // The illegal size code is handled separately by the caller.
   function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = (lo != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   // Rounds the byte offset down to the access size.
   function automatic logic [1:0] force_align(input size_e size, input logic [1:0] lo);
      logic [1:0] res;
      res = lo;
      case (size)
         SZ_HALF: res = {lo[1], 1'b0};
         SZ_WORD: res = 2'b00;
         default: res = lo;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Bundles the request/response handshake from the MEM stage and the
// word-addressed data-memory port.
//   master : the environment (pipeline drives requests, memory returns data)
//   slave  : the load/store unit
// Signals:
//   req_valid/req_ready        request handshake
//   req_write/size/signed      access type
//   req_addr/req_wdata         byte address, right-justified store data
//   resp_valid/rdata/error     single-cycle completion
//   mem_address/mem_write_data memory word address (low bits 0) and write word
//   MemRead/MemWrite           memory enables
//   mem_read_data              memory read word, valid while MemRead is high
// -----------------------------------------------------------------------------
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] mem_read_data;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  mem_address, mem_write_data, MemRead, MemWrite,
      output mem_read_data
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output mem_address, mem_write_data, MemRead, MemWrite,
      input  mem_read_data
   );
endinterface

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align (combinational)
// Lane steering between a memory word and a sub-word access.
// Ports:
//   word       in  32  memory word as read
//   addr_lo    in  2   byte offset of the access (already aligned to size)
//   size       in      access size
//   is_signed  in  1   sign-extend sub-word loads
//   wdata      in  32  right-justified store data
//   load_data  out 32  selected lane(s), sign/zero extended
//   store_data out 32  word with the addressed lane(s) replaced by wdata
// BIG_ENDIAN=1 puts byte offset 0 in bits 31:24, otherwise in bits 7:0.
// -----------------------------------------------------------------------------
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  size_e       size,
   input  logic        is_signed,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   // Physical byte / halfword position inside the word for this offset.
   logic [1:0]  byte_pos;
   logic        half_pos;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] wdata_rep;

   assign byte_pos = BIG_ENDIAN ? ~addr_lo : addr_lo;
   assign half_pos = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
   assign sel_byte = word[{byte_pos, 3'b000} +: 8];
   assign sel_half = word[{half_pos, 4'b0000} +: 16];

   always_comb begin
      load_data = word;
      case (size)
         SZ_BYTE: load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
         SZ_HALF: load_data = {{16{is_signed & sel_half[15]}}, sel_half};
         default: load_data = word;
      endcase
   end

   // Replicating the store data across the word lets every physical lane
   // pick its byte from the same position it occupies in the word.
   always_comb begin
      wdata_rep = wdata;
      case (size)
         SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
         SZ_HALF: wdata_rep = {2{wdata[15:0]}};
         default: wdata_rep = wdata;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      // Byte offset that maps onto physical byte gi.
      localparam logic [1:0] LANE = BIG_ENDIAN ? 2'(3 - gi) : 2'(gi);
      logic lane_hit;

      always_comb begin
         lane_hit = 1'b1;
         case (size)
            SZ_BYTE: lane_hit = (addr_lo == LANE);
            SZ_HALF: lane_hit = (addr_lo[1] == LANE[1]);
            default: lane_hit = 1'b1;
         endcase
      end

      assign store_data[8*gi +: 8] = lane_hit ? wdata_rep[8*gi +: 8] : word[8*gi +: 8];
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the CPU data-memory interface. Accepts one request at a
// time from the MEM stage, drives a word-wide MemRead/MemWrite port, extracts
// and extends sub-word loads, performs read-modify-write for sub-word stores
// and returns a one-cycle response. Misaligned or illegal-size requests are
// answered with resp_error without touching memory.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high
//   bus    lsu_if.slave  request/response handshake and memory port
// Latency from the accepting edge to resp_valid: error 1, load and word
// store 2, sub-word store 3 cycles. req_ready is high only in IDLE.
// -----------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter bit BIG_ENDIAN  = 1'b1,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic clk,
   input  logic reset,
   lsu_if.slave bus
);

   state_e      state_reg, state_next;

   // Latched request
   logic        lat_write_reg,   lat_write_next;
   size_e       lat_size_reg,    lat_size_next;
   logic        lat_signed_reg,  lat_signed_next;
   logic [1:0]  lat_addr_lo_reg, lat_addr_lo_next;
   logic [31:0] lat_wdata_reg,   lat_wdata_next;

   // Registered outputs
   logic [31:0] mem_address_reg,    mem_address_next;
   logic [31:0] mem_write_data_reg, mem_write_data_next;
   logic [31:0] resp_rdata_reg,     resp_rdata_next;
   logic        resp_error_reg,     resp_error_next;

   // Decoded outputs
   logic        req_ready;
   logic        mem_read_en;
   logic        mem_write_en;
   logic        resp_valid;

   size_e       req_size_e;
   logic        req_bad;
   logic [31:0] load_data;
   logic [31:0] store_data;

   assign req_size_e = size_e'(bus.req_size);
   assign req_bad    = (req_size_e == SZ_ILLEGAL) ||
                       (ALIGN_CHECK && is_misaligned(req_size_e, bus.req_addr[1:0]));

   // One lane aligner serves both the load extract (RD, load) and the store
   // merge (RD, sub-word store); both look at the word being read.
   lsu_lane_align #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane_align (
      .word       (bus.mem_read_data),
      .addr_lo    (lat_addr_lo_reg),
      .size       (lat_size_reg),
      .is_signed  (lat_signed_reg),
      .wdata      (lat_wdata_reg),
      .load_data  (load_data),
      .store_data (store_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_write_reg      <= 1'b0;
         lat_size_reg       <= SZ_BYTE;
         lat_signed_reg     <= 1'b0;
         lat_addr_lo_reg    <= 2'b00;
         lat_wdata_reg      <= 32'h0;
         mem_address_reg    <= 32'h0;
         mem_write_data_reg <= 32'h0;
         resp_rdata_reg     <= 32'h0;
         resp_error_reg     <= 1'b0;
      end else begin
         lat_write_reg      <= lat_write_next;
         lat_size_reg       <= lat_size_next;
         lat_signed_reg     <= lat_signed_next;
         lat_addr_lo_reg    <= lat_addr_lo_next;
         lat_wdata_reg      <= lat_wdata_next;
         mem_address_reg    <= mem_address_next;
         mem_write_data_reg <= mem_write_data_next;
         resp_rdata_reg     <= resp_rdata_next;
         resp_error_reg     <= resp_error_next;
      end
   end

   always_comb begin
      state_next          = state_reg;
      lat_write_next      = lat_write_reg;
      lat_size_next       = lat_size_reg;
      lat_signed_next     = lat_signed_reg;
      lat_addr_lo_next    = lat_addr_lo_reg;
      lat_wdata_next      = lat_wdata_reg;
      mem_address_next    = mem_address_reg;
      mem_write_data_next = mem_write_data_reg;
      resp_rdata_next     = resp_rdata_reg;
      resp_error_next     = resp_error_reg;
      req_ready           = 1'b0;
      mem_read_en         = 1'b0;
      mem_write_en        = 1'b0;
      resp_valid          = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               lat_write_next   = bus.req_write;
               lat_size_next    = req_size_e;
               lat_signed_next  = bus.req_signed;
               lat_wdata_next   = bus.req_wdata;
               // Without the alignment check, unused offset bits are dropped
               // so the lane aligner always sees a naturally aligned offset.
               lat_addr_lo_next = ALIGN_CHECK ? bus.req_addr[1:0]
                                              : force_align(req_size_e, bus.req_addr[1:0]);
               if (req_bad) begin
                  state_next      = ST_RESP;
                  resp_error_next = 1'b1;
                  resp_rdata_next = 32'h0;
               end else begin
                  mem_address_next = {bus.req_addr[31:2], 2'b00};
                  if (bus.req_write && (req_size_e == SZ_WORD)) begin
                     state_next          = ST_WR;
                     mem_write_data_next = bus.req_wdata;
                  end else begin
                     state_next = ST_RD;
                  end
               end
            end
         end

         ST_RD: begin
            mem_read_en = 1'b1;
            if (lat_write_reg) begin
               mem_write_data_next = store_data;
               state_next          = ST_WR;
            end else begin
               resp_rdata_next = load_data;
               state_next      = ST_RESP;
            end
         end

         ST_WR: begin
            mem_write_en = 1'b1;
            state_next   = ST_RESP;
         end

         ST_RESP: begin
            resp_valid = 1'b1;
            // Response fields read as zero once the pulse is over.
            resp_rdata_next = 32'h0;
            resp_error_next = 1'b0;
            state_next      = ST_IDLE;
         end

         default: state_next = ST_IDLE;
      endcase
   end

   assign bus.req_ready      = req_ready;
   assign bus.resp_valid     = resp_valid;
   assign bus.resp_rdata     = resp_rdata_reg;
   assign bus.resp_error     = resp_error_reg;
   assign bus.mem_address    = mem_address_reg;
   assign bus.mem_write_data = mem_write_data_reg;
   assign bus.MemRead        = mem_read_en;
   assign bus.MemWrite       = mem_write_en;

endmodule
